avl_ram: RTL and testbench

On-chip block-RAM stand-in for the DDR3 controller: an Avalon-MM responder that accepts the same command/burst traffic the `switch` block issues on its `avl_*` port and returns read data with controller-like latency. It is used for bring-up and simulation without the external DDR3 device. It also reproduces the controller's `local_init_done` and `local_cal_*` status behaviour.

---
 rtl/avl_ram.sv | 144 ++++++++++++++
 tb/tb_avl_ram.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_ram.sv
// Block-RAM stand-in for the DDR3 controller's Avalon-MM port: burst writes,
// fixed-latency burst reads, and controller-style init/calibration status.
module avl_ram #(
  parameter int ADDR_BITS    = 12,
  parameter int READ_LATENCY = 4,
  parameter int INIT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [25:0] avl_addr,
  input  logic        avl_burstbegin,
  input  logic [2:0]  avl_size,
  input  logic        avl_read_req,
  input  logic        avl_write_req,
  input  logic [31:0] avl_wdata,
  output logic        avl_ready,
  output logic        avl_rdata_valid,
  output logic [31:0] avl_rdata,
  output logic        local_init_done,
  output logic        local_cal_success,
  output logic        local_cal_fail
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_WBURST = 3'd2;
  localparam logic [2:0] S_RWAIT  = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;

  localparam int ICW   = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0]          mem [0:DEPTH-1];

  logic [2:0]           state_q,    state_d;
  logic [ICW-1:0]       init_cnt_q, init_cnt_d;
  logic [3:0]           lat_cnt_q,  lat_cnt_d;
  logic [ADDR_BITS-1:0] addr_q,     addr_d;
  logic [3:0]           remain_q,   remain_d;
  logic                 done_q,     done_d;
  logic                 rvalid_q,   rvalid_d;
  logic [31:0]          rdata_q,    rdata_d;

  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [3:0]           size_eff;
  logic                 unused_addr_hi;

  // Upper address bits alias onto the implemented depth.
  assign cmd_addr       = avl_addr[ADDR_BITS-1:0];
  assign unused_addr_hi = ^avl_addr[25:ADDR_BITS];
  assign size_eff       = (avl_size == 3'd0) ? 4'd1 : {1'b0, avl_size};

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    done_d     = done_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    we         = 1'b0;
    waddr      = addr_q;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == ICW'(INIT_CYCLES - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      S_IDLE, S_WBURST: begin
        // A burstbegin beat restarts the burst even mid-WBURST.
        if (avl_write_req && ((state_q == S_IDLE) || avl_burstbegin)) begin
          we       = 1'b1;
          waddr    = cmd_addr;
          addr_d   = cmd_addr + 1'b1;
          remain_d = size_eff - 1'b1;
          state_d  = (size_eff > 4'd1) ? S_WBURST : S_IDLE;
        end else if (avl_write_req) begin
          we       = 1'b1;
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == 4'd1) state_d = S_IDLE;
        end else if (avl_read_req && (state_q == S_IDLE)) begin
          addr_d    = cmd_addr;
          remain_d  = size_eff;
          lat_cnt_d = '0;
          state_d   = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (lat_cnt_q == 4'(READ_LATENCY - 2)) state_d = S_RDATA;
        else lat_cnt_d = lat_cnt_q + 1'b1;
      end
      S_RDATA: begin
        rvalid_d = 1'b1;
        rdata_d  = mem[addr_q];
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        if (remain_q == 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      lat_cnt_q  <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      done_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      done_q     <= done_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= avl_wdata;
  end

  assign avl_ready         = (state_q == S_IDLE) || (state_q == S_WBURST);
  assign avl_rdata_valid   = rvalid_q;
  assign avl_rdata         = rdata_q;
  assign local_init_done   = done_q;
  assign local_cal_success = done_q;
  assign local_cal_fail    = 1'b0;

endmodule

// File: tb/tb_avl_ram.sv
// Self-checking bench for avl_ram: directed scenarios plus randomized bursts
// checked against an array model of the word-addressed RAM.
module tb_avl_ram;
  localparam int AB    = 12;
  localparam int RL    = 4;
  localparam int IC    = 64;
  localparam int DEPTH = 1 << AB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [25:0] avl_addr = '0;
  logic        avl_burstbegin = 1'b0;
  logic [2:0]  avl_size = '0;
  logic        avl_read_req = 1'b0;
  logic        avl_write_req = 1'b0;
  logic [31:0] avl_wdata = '0;
  logic        avl_ready;
  logic        avl_rdata_valid;
  logic [31:0] avl_rdata;
  logic        local_init_done;
  logic        local_cal_success;
  logic        local_cal_fail;

  always #5 clk = ~clk;

  avl_ram #(.ADDR_BITS(AB), .READ_LATENCY(RL), .INIT_CYCLES(IC)) dut (
    .clk(clk), .rst(rst), .avl_addr(avl_addr), .avl_burstbegin(avl_burstbegin),
    .avl_size(avl_size), .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
    .avl_wdata(avl_wdata), .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid),
    .avl_rdata(avl_rdata), .local_init_done(local_init_done),
    .local_cal_success(local_cal_success), .local_cal_fail(local_cal_fail)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];

  // Results of the most recent read transaction.
  int          r_wait, r_lat, r_nb, r_rdy;
  bit          r_contig;
  logic [31:0] r_got [8];

  function automatic int eff(input logic [2:0] s);
    return (s == 3'd0) ? 1 : int'(s);
  endfunction

  function automatic int widx(input logic [25:0] a, input int k);
    return (int'(a) + k) % DEPTH;
  endfunction

  task automatic model_wr(input logic [25:0] a, input int k, input logic [31:0] d);
    ref_mem[widx(a, k)] = d;
    known[widx(a, k)]   = 1'b1;
  endtask

  task automatic wbeat(input logic [25:0] a, input logic [2:0] sz, input logic bb, input logic [31:0] d);
    avl_write_req = 1'b1; avl_read_req = 1'b0; avl_burstbegin = bb;
    avl_addr = a; avl_size = sz; avl_wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    avl_write_req = 1'b0; avl_read_req = 1'b0; avl_burstbegin = 1'b0;
  endtask

  // Issue one read and record beat timing relative to the accepting edge (c=0).
  task automatic rd(input logic [25:0] a, input logic [2:0] sz);
    int prev;
    avl_addr = a; avl_size = sz; avl_read_req = 1'b1;
    avl_write_req = 1'b0; avl_burstbegin = 1'b0;
    r_wait = 0;
    while (avl_ready !== 1'b1 && r_wait < 200) begin
      @(negedge clk);
      r_wait++;
    end
    @(negedge clk);
    avl_read_req = 1'b0;
    r_lat = -1; r_nb = 0; r_contig = 1'b1; r_rdy = -1; prev = -1;
    for (int i = 0; i < 8; i++) r_got[i] = '0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (avl_rdata_valid === 1'b1) begin
        if (r_lat < 0) r_lat = c;
        else if (c != prev + 1) r_contig = 1'b0;
        if (r_nb < 8) r_got[r_nb] = avl_rdata;
        r_nb++;
        prev = c;
      end
      if (r_rdy < 0 && avl_ready === 1'b1) r_rdy = c;
    end
  endtask

  task automatic test_reset();
    logic e;
    @(negedge clk);
    chk_cnt++;
    if ({avl_ready, avl_rdata_valid, local_init_done, local_cal_success, local_cal_fail} !== 5'b0 ||
        avl_rdata !== 32'h0)
      $display("FAIL reset_values: ready=%b valid=%b rdata=%h done=%b succ=%b fail=%b required all 0",
               avl_ready, avl_rdata_valid, avl_rdata, local_init_done, local_cal_success, local_cal_fail);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= IC + 6; c++) begin
      @(negedge clk);
      e = (c >= IC);
      chk_cnt++;
      if (local_init_done !== e || local_cal_success !== e || avl_ready !== e || local_cal_fail !== 1'b0)
        $display("FAIL init_seq c=%0d: done=%b succ=%b ready=%b fail=%b required done=succ=ready=%b fail=0",
                 c, local_init_done, local_cal_success, avl_ready, local_cal_fail, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    wbeat(26'h10, 3'd1, 1'b1, 32'hDEADBEEF);
    model_wr(26'h10, 0, 32'hDEADBEEF);
    idle();
    rd(26'h10, 3'd1);
    chk_cnt++;
    if (r_wait !== 0 || r_lat !== RL || r_nb !== 1 || r_rdy !== RL)
      $display("FAIL single_timing: wait=%0d lat=%0d beats=%0d ready_at=%0d required 0/%0d/1/%0d",
               r_wait, r_lat, r_nb, r_rdy, RL, RL);
    else pass_cnt++;
    chk_cnt++;
    if (r_got[0] !== 32'hDEADBEEF) $display("FAIL single_data: got %h required DEADBEEF", r_got[0]);
    else pass_cnt++;
    // Upper address bits alias onto the same word.
    rd(26'h3FF_F010, 3'd1);
    chk_cnt++;
    if (r_nb !== 1 || r_got[0] !== 32'hDEADBEEF)
      $display("FAIL alias_data: beats=%0d got %h required 1 beat DEADBEEF", r_nb, r_got[0]);
    else pass_cnt++;
  endtask

  task automatic test_burst_wrap();
    logic [31:0] exp4 [4];
    logic [25:0] base;
    base = 26'(DEPTH - 2);
    for (int k = 0; k < 4; k++) begin
      wbeat(base, 3'd4, (k == 0), 32'(k + 1));
      model_wr(base, k, 32'(k + 1));
    end
    idle();
    rd(base, 3'd4);
    chk_cnt++;
    if (r_lat !== RL || r_nb !== 4 || !r_contig || r_rdy !== RL + 3)
      $display("FAIL wrap_timing: lat=%0d beats=%0d contig=%b ready_at=%0d required %0d/4/1/%0d",
               r_lat, r_nb, r_contig, r_rdy, RL, RL + 3);
    else pass_cnt++;
    exp4[0] = 32'd1; exp4[1] = 32'd2; exp4[2] = 32'd3; exp4[3] = 32'd4;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if (r_got[k] !== exp4[k]) $display("FAIL wrap_beat%0d: got %h required %h", k, r_got[k], exp4[k]);
      else pass_cnt++;
    end
    rd(26'h0, 3'd2);
    chk_cnt++;
    if (r_nb !== 2 || r_got[0] !== 32'd3 || r_got[1] !== 32'd4)
      $display("FAIL wrap_addr0: beats=%0d got %h,%h required 2 beats 3,4", r_nb, r_got[0], r_got[1]);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    avl_addr = 26'h20; avl_size = 3'd1; avl_wdata = 32'hA5A5_0020;
    avl_write_req = 1'b1; avl_burstbegin = 1'b1; avl_read_req = 1'b1;
    model_wr(26'h20, 0, 32'hA5A5_0020);
    @(negedge clk);
    chk_cnt++;
    if (avl_ready !== 1'b1 || avl_rdata_valid !== 1'b0)
      $display("FAIL collision_write_wins: ready=%b valid=%b required ready=1 valid=0", avl_ready, avl_rdata_valid);
    else pass_cnt++;
    avl_write_req = 1'b0; avl_burstbegin = 1'b0;
    rd(26'h20, 3'd1);
    chk_cnt++;
    if (r_wait !== 0 || r_lat !== RL || r_nb !== 1 || r_got[0] !== 32'hA5A5_0020)
      $display("FAIL collision_held_read: wait=%0d lat=%0d beats=%0d data=%h required 0/%0d/1/a5a50020",
               r_wait, r_lat, r_nb, r_got[0], RL);
    else pass_cnt++;
  endtask

  task automatic test_truncate();
    logic [25:0] base;
    base = 26'h80;
    for (int k = 0; k < 4; k++) begin
      wbeat(base, 3'd4, (k == 0), 32'hA000_0000 + 32'(k));
      model_wr(base, k, 32'hA000_0000 + 32'(k));
    end
    wbeat(26'h40, 3'd1, 1'b1, 32'h5555_5555);
    model_wr(26'h40, 0, 32'h5555_5555);
    wbeat(base, 3'd4, 1'b1, 32'hC0);
    model_wr(base, 0, 32'hC0);
    wbeat(base, 3'd4, 1'b0, 32'hC1);
    model_wr(base, 1, 32'hC1);
    wbeat(26'h40, 3'd1, 1'b1, 32'hC2);
    model_wr(26'h40, 0, 32'hC2);
    idle();
    rd(base, 3'd4);
    chk_cnt++;
    if (r_nb !== 4) $display("FAIL trunc_beats: got %0d required 4", r_nb);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if (r_got[k] !== ref_mem[widx(base, k)])
        $display("FAIL trunc_beat%0d: got %h required %h", k, r_got[k], ref_mem[widx(base, k)]);
      else pass_cnt++;
    end
    rd(26'h40, 3'd1);
    chk_cnt++;
    if (r_got[0] !== 32'hC2) $display("FAIL trunc_new_burst: got %h required c2", r_got[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int seen, c_done, spurious;
    for (int k = 0; k < 7; k++) begin
      wbeat(26'h200, 3'd7, (k == 0), 32'hB000_0000 + 32'(k * 17));
      model_wr(26'h200, k, 32'hB000_0000 + 32'(k * 17));
    end
    idle();
    avl_addr = 26'h200; avl_size = 3'd7; avl_read_req = 1'b1;
    @(negedge clk);
    avl_read_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 24 && seen < 3; c++) begin
      @(negedge clk);
      if (avl_rdata_valid === 1'b1) begin
        chk_cnt++;
        if (avl_rdata !== ref_mem[widx(26'h200, seen)])
          $display("FAIL rstmid_beat%0d: got %h required %h", seen, avl_rdata, ref_mem[widx(26'h200, seen)]);
        else pass_cnt++;
        seen++;
      end
    end
    chk_cnt++;
    if (seen !== 3) $display("FAIL rstmid_prefix: saw %0d beats required 3", seen);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (avl_rdata_valid !== 1'b0 || avl_ready !== 1'b0 || local_init_done !== 1'b0 || avl_rdata !== 32'h0)
      $display("FAIL rstmid_async: valid=%b ready=%b done=%b rdata=%h required 0/0/0/0",
               avl_rdata_valid, avl_ready, local_init_done, avl_rdata);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    c_done = -1; spurious = 0;
    for (int c = 1; c <= IC + 10 && c_done < 0; c++) begin
      @(negedge clk);
      if (avl_rdata_valid === 1'b1) spurious++;
      if (local_init_done === 1'b1) c_done = c;
    end
    chk_cnt++;
    if (spurious !== 0 || c_done !== IC)
      $display("FAIL rstmid_reinit: stray_beats=%0d done_at=%0d required 0 and %0d", spurious, c_done, IC);
    else pass_cnt++;
    rd(26'h200, 3'd7);
    chk_cnt++;
    if (r_nb !== 7 || r_lat !== RL || !r_contig)
      $display("FAIL rstmid_reread_timing: beats=%0d lat=%0d contig=%b required 7/%0d/1", r_nb, r_lat, r_contig, RL);
    else pass_cnt++;
    for (int k = 0; k < 7; k++) begin
      chk_cnt++;
      if (r_got[k] !== ref_mem[widx(26'h200, k)])
        $display("FAIL rstmid_keep%0d: got %h required %h", k, r_got[k], ref_mem[widx(26'h200, k)]);
      else pass_cnt++;
    end
    rd(26'h10, 3'd1);
    chk_cnt++;
    if (r_got[0] !== 32'hDEADBEEF) $display("FAIL rstmid_keep_10: got %h required DEADBEEF", r_got[0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [25:0] bases [$];
    logic [25:0] a;
    logic [2:0]  sz;
    logic [31:0] d;
    int          n;
    logic        bb0;
    for (int it = 0; it < 8; it++) begin
      a   = 26'($urandom);
      sz  = 3'($urandom_range(0, 7));
      n   = eff(sz);
      bb0 = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        d = $urandom;
        wbeat(a, sz, (k == 0) ? bb0 : 1'b0, d);
        model_wr(a, k, d);
      end
      bases.push_back(a);
    end
    idle();
    for (int it = 0; it < 14; it++) begin
      a  = bases[$urandom_range(0, bases.size() - 1)] + 26'($urandom_range(0, 3));
      sz = 3'($urandom_range(0, 7));
      n  = eff(sz);
      rd(a, sz);
      chk_cnt++;
      if (r_wait !== 0 || r_lat !== RL || r_nb !== n || !r_contig || r_rdy !== RL + n - 1)
        $display("FAIL rand_timing it=%0d: wait=%0d lat=%0d beats=%0d contig=%b ready_at=%0d required 0/%0d/%0d/1/%0d",
                 it, r_wait, r_lat, r_nb, r_contig, r_rdy, RL, n, RL + n - 1);
      else pass_cnt++;
      for (int k = 0; k < n; k++) begin
        if (known[widx(a, k)]) begin
          chk_cnt++;
          if (r_got[k] !== ref_mem[widx(a, k)])
            $display("FAIL rand_data it=%0d beat%0d addr=%h: got %h required %h",
                     it, k, widx(a, k), r_got[k], ref_mem[widx(a, k)]);
          else pass_cnt++;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    test_reset();
    test_single();
    test_burst_wrap();
    test_collision();
    test_truncate();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
